// File: rtl/ma_out_accumulator_pkg.sv
// Shared types and requantization helpers for the systolic-array output stages.
// The requant function works on a 64-bit signed value so callers of any lane width can reuse it.
package ma_out_accumulator_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StDrain = 2'd2
   } state_e;

   localparam int unsigned DefDataLength  = 8;
   localparam int unsigned DefMeshLength  = 4;
   localparam int unsigned DefAccLength   = 32;
   localparam int unsigned DefKWidth      = 8;
   localparam int unsigned DefShiftWidth  = 5;
   localparam int unsigned ReqWidth       = 64;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

   // Round half up, arithmetic shift, then saturate to a signed dlen-bit range.
   function automatic logic signed [ReqWidth-1:0] requant(input logic signed [ReqWidth-1:0] acc,
                                                          input int unsigned shift,
                                                          input int unsigned dlen);
      logic signed [ReqWidth-1:0] v;
      logic signed [ReqWidth-1:0] hi;
      logic signed [ReqWidth-1:0] lo;
      v = acc;
      if (shift > 0) begin
         v = v + (64'sd1 <<< (shift - 1));
      end
      v  = v >>> shift;
      hi = (64'sd1 <<< (dlen - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dlen - 1));
      if (v > hi) begin
         v = hi;
      end else if (v < lo) begin
         v = lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/ma_requant_lane.sv
// Combinational requantization of one accumulator lane to an output lane.
// MA_ACC_RELU_EN clamps negative accumulations to zero before rounding.
module ma_requant_lane
   import ma_out_accumulator_pkg::*;
#(
   parameter int unsigned acc_length  = DefAccLength,
   parameter int unsigned data_length = DefDataLength,
   parameter int unsigned shift_width = DefShiftWidth
) (
   input  logic [acc_length-1:0]  acc,
   input  logic [shift_width-1:0] shift,
   output logic [data_length-1:0] q
);

   logic signed [ReqWidth-1:0] ext;

   always_comb begin
      ext = ReqWidth'(signed'(acc));
`ifdef MA_ACC_RELU_EN
      if (ext < 0) begin
         ext = '0;
      end
`endif
      q = data_length'(requant(ext, 32'(shift), data_length));
   end

endmodule

// File: rtl/ma_out_accumulator.sv
// Accumulates K passes of systolic-array row tiles, then drains requantized rows over valid/ready.
// Optional MA_ACC_RELU_EN (in ma_requant_lane) makes the output non-negative.
module ma_out_accumulator
   import ma_out_accumulator_pkg::*;
#(
   parameter int unsigned data_length = DefDataLength,
   parameter int unsigned mesh_length = DefMeshLength,
   parameter int unsigned acc_length  = DefAccLength,
   parameter int unsigned k_width     = DefKWidth,
   parameter int unsigned shift_width = DefShiftWidth
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_start,
   input  logic [k_width-1:0]                cfg_k_tiles,
   input  logic [shift_width-1:0]            cfg_shift,
   input  logic                              in_valid,
   input  logic [acc_length*mesh_length-1:0] in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [data_length*mesh_length-1:0] out_data,
   output logic                              out_last,
   output logic                              busy,
   output logic                              err_drop
);

   localparam int unsigned RowW = cnt_width(mesh_length);
   localparam logic [RowW-1:0] LastRow = RowW'(mesh_length - 1);

   state_e                            state_q, state_d;
   logic [RowW-1:0]                   row_cnt_q, row_cnt_d;
   logic [RowW-1:0]                   drain_row_q, drain_row_d;
   logic [k_width-1:0]                tile_cnt_q, tile_cnt_d;
   logic [k_width-1:0]                k_q, k_d;
   logic [shift_width-1:0]            shift_q, shift_d;
   logic [acc_length*mesh_length-1:0] acc_buf_q [mesh_length];
   logic [acc_length*mesh_length-1:0] row_sum;
   logic [acc_length*mesh_length-1:0] drain_acc;
   logic [data_length*mesh_length-1:0] requant_row;
   logic                              row_wr;
   logic                              err_drop_q;
   logic                              last_row;
   logic                              last_pass;

   assign last_row  = (row_cnt_q == LastRow);
   assign last_pass = (tile_cnt_q == (k_q - k_width'(1)));

   // First pass overwrites so stale data from a previous tile never leaks in.
   always_comb begin
      row_sum = '0;
      for (int unsigned i = 0; i < mesh_length; i++) begin
         if (tile_cnt_q == '0) begin
            row_sum[lane_lsb(i, acc_length) +: acc_length] =
               in_data[lane_lsb(i, acc_length) +: acc_length];
         end else begin
            row_sum[lane_lsb(i, acc_length) +: acc_length] =
               acc_buf_q[row_cnt_q][lane_lsb(i, acc_length) +: acc_length] +
               in_data[lane_lsb(i, acc_length) +: acc_length];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      drain_row_d = drain_row_q;
      tile_cnt_d  = tile_cnt_q;
      k_d         = k_q;
      shift_d     = shift_q;
      row_wr      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_start) begin
               k_d         = (cfg_k_tiles == '0) ? k_width'(1) : cfg_k_tiles;
               shift_d     = cfg_shift;
               row_cnt_d   = '0;
               tile_cnt_d  = '0;
               drain_row_d = '0;
               state_d     = StAccum;
            end
         end
         StAccum: begin
            if (in_valid) begin
               row_wr = 1'b1;
               if (last_row) begin
                  row_cnt_d  = '0;
                  tile_cnt_d = tile_cnt_q + k_width'(1);
                  if (last_pass) begin
                     drain_row_d = '0;
                     state_d     = StDrain;
                  end
               end else begin
                  row_cnt_d = row_cnt_q + RowW'(1);
               end
            end
         end
         StDrain: begin
            if (out_ready) begin
               if (drain_row_q == LastRow) begin
                  state_d = StIdle;
               end else begin
                  drain_row_d = drain_row_q + RowW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         row_cnt_q   <= '0;
         drain_row_q <= '0;
         tile_cnt_q  <= '0;
         k_q         <= '0;
         shift_q     <= '0;
         err_drop_q  <= 1'b0;
         for (int unsigned r = 0; r < mesh_length; r++) begin
            acc_buf_q[r] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         drain_row_q <= drain_row_d;
         tile_cnt_q  <= tile_cnt_d;
         k_q         <= k_d;
         shift_q     <= shift_d;
         err_drop_q  <= in_valid && (state_q != StAccum);
         if (row_wr) begin
            acc_buf_q[row_cnt_q] <= row_sum;
         end
      end
   end

   assign drain_acc = acc_buf_q[drain_row_q];

   for (genvar i = 0; i < mesh_length; i++) begin : g_lane
      ma_requant_lane #(
         .acc_length  (acc_length),
         .data_length (data_length),
         .shift_width (shift_width)
      ) u_requant_lane (
         .acc   (drain_acc[i*acc_length +: acc_length]),
         .shift (shift_q),
         .q     (requant_row[i*data_length +: data_length])
      );
   end

   assign out_valid = (state_q == StDrain);
   assign out_data  = out_valid ? requant_row : '0;
   assign out_last  = out_valid && (drain_row_q == LastRow);
   assign busy      = (state_q != StIdle);
   assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_ma_out_accumulator.sv
// Self-checking bench for ma_out_accumulator: vector table plus hand sequences, scoreboard on drain.
module tb_ma_out_accumulator;

`ifdef MA_ACC_RELU_EN
   localparam bit Relu = 1'b1;
`else
   localparam bit Relu = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start;
   logic [7:0]   cfg_k_tiles;
   logic [4:0]   cfg_shift;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         out_last;
   logic         busy;
   logic         err_drop;

   always #5 clk = ~clk;

   ma_out_accumulator #(
      .data_length (8),
      .mesh_length (4),
      .acc_length  (32),
      .k_width     (8),
      .shift_width (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_start   (cfg_start),
      .cfg_k_tiles (cfg_k_tiles),
      .cfg_shift   (cfg_shift),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .err_drop    (err_drop)
   );

   typedef struct {
      logic [7:0]        k;
      logic [4:0]        sh;
      logic [3:0][31:0]  p0;
      logic [3:0][31:0]  pn;
      logic [31:0]       ex;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] ref_lane(input logic [31:0] a, input int sh);
      longint v;
      v = longint'(signed'(a));
      if (Relu && v < 0) v = 0;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
      return v[7:0];
   endfunction

   function automatic logic [31:0] model_row(input logic [127:0] acc, input int sh);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) r[l*8 +: 8] = ref_lane(acc[l*32 +: 32], sh);
      return r;
   endfunction

   task automatic push_exp(input logic [31:0] d, input logic last);
      exp_t e;
      e.data = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic start(input logic [7:0] k, input logic [4:0] sh);
      cfg_start   = 1'b1;
      cfg_k_tiles = k;
      cfg_shift   = sh;
      @(posedge clk); #1;
      cfg_start   = 1'b0;
   endtask

   task automatic beat(input logic [127:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d, expected busy=0 pending=0",
                  busy, exp_q.size());
         exp_q.delete();
      end
      check("idle_valid", out_valid, 0);
      @(posedge clk); #1;
   endtask

   // Scoreboard: every accepted output row is compared against the queued expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_row: got %0h, expected no row", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data", out_data, mon_e.data);
            check("out_last", out_last, mon_e.last);
         end
      end
   end

   initial begin
      vec_t             vecs[6];
      logic [3:0][31:0] rows[4];
      logic [31:0]      ex_rows[4];
      int               keff;

      cfg_start = 0; cfg_k_tiles = 0; cfg_shift = 0;
      in_valid = 0; in_data = '0; out_ready = 1;

      vecs[0] = '{8'd1, 5'd0, {-32'sd200, 32'sd200, -32'sd3, 32'sd5}, '0,
                  Relu ? 32'h007f0005 : 32'h807ffd05};
      vecs[1] = '{8'd2, 5'd2, {96'd0, 32'd100}, {96'd0, 32'd50}, 32'h00000026};
      vecs[2] = '{8'd0, 5'd0, {32'sd1, -32'sd1, 32'sd7, -32'sd200}, '0,
                  Relu ? 32'h01000700 : 32'h01ff0780};
      vecs[3] = '{8'd3, 5'd4, {-32'sd24, 32'sd16, -32'sd1000, 32'sd1000},
                  {-32'sd8, 32'sd8, -32'sd10, 32'sd10},
                  Relu ? 32'h00020040 : 32'hfe02c040};
      vecs[4] = '{8'd1, 5'd31, {32'hffffffff, 32'h0, 32'h80000000, 32'h7fffffff}, '0,
                  Relu ? 32'h00000001 : 32'h0000ff01};
      vecs[5] = '{8'd2, 5'd0, {96'd0, 32'h7fffffff}, {96'd0, 32'd1},
                  Relu ? 32'h00000000 : 32'h00000080};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err_drop", err_drop, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         keff = (vecs[i].k == 0) ? 1 : int'(vecs[i].k);
         for (int r = 0; r < 4; r++) push_exp(vecs[i].ex, r == 3);
         start(vecs[i].k, vecs[i].sh);
         check("busy_accum", busy, 1);
         for (int p = 0; p < keff; p++) begin
            for (int r = 0; r < 4; r++) begin
               beat((p == 0) ? vecs[i].p0 : vecs[i].pn);
               if (p == 0 && r == 0) check("no_early_valid", out_valid, 0);
            end
         end
         check("drain_latency", out_valid, 1);
         wait_idle(20);
      end

      // Distinct rows, a stall at row 1, and a cfg_start while busy that must be ignored.
      for (int r = 0; r < 4; r++) begin
         rows[r][0] = 32'(r * 10 + 1);
         rows[r][1] = 32'(-(r * 10 + 2));
         rows[r][2] = 32'(r * 1000);
         rows[r][3] = 32'(-r * 300 - 5);
         ex_rows[r] = model_row(rows[r], 3);
         push_exp(ex_rows[r], r == 3);
      end
      start(8'd1, 5'd3);
      beat(rows[0]);
      beat(rows[1]);
      start(8'd5, 5'd0);
      beat(rows[2]);
      beat(rows[3]);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, ex_rows[1]);
         check("stall_last", out_last, 0);
      end
      out_ready = 1'b1;
      wait_idle(20);

      // Beat dropped alongside cfg_start in IDLE, then another dropped during DRAIN.
      for (int r = 0; r < 4; r++) begin
         rows[r] = {32'(-7), 32'(64 * r), 32'(-(r + 1) * 50), 32'(r + 1)};
         ex_rows[r] = model_row(rows[r], 1);
         push_exp(ex_rows[r], r == 3);
      end
      out_ready   = 1'b0;
      cfg_start   = 1'b1;
      cfg_k_tiles = 8'd1;
      cfg_shift   = 5'd1;
      in_valid    = 1'b1;
      in_data     = {4{32'd999}};
      @(posedge clk); #1;
      cfg_start = 1'b0;
      in_valid  = 1'b0;
      check("err_drop_idle", err_drop, 1);
      beat(rows[0]);
      check("err_drop_clear", err_drop, 0);
      for (int r = 1; r < 4; r++) beat(rows[r]);
      beat({4{32'h5a5a5a5a}});
      check("err_drop_drain", err_drop, 1);
      @(posedge clk); #1;
      check("err_drop_pulse", err_drop, 0);
      check("drain_held", out_data, ex_rows[0]);
      out_ready = 1'b1;
      wait_idle(20);

      // Asynchronous reset mid-accumulation, then a fresh tile.
      start(8'd1, 5'd0);
      beat({4{32'd77}});
      beat({4{32'd88}});
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_last", out_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 4; r++) begin
         rows[r] = {32'(4 * r), 32'(3 * r), 32'(2 * r), 32'(r)};
         ex_rows[r] = model_row(rows[r], 0);
         push_exp(ex_rows[r], r == 3);
      end
      start(8'd1, 5'd0);
      for (int r = 0; r < 4; r++) beat(rows[r]);
      wait_idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
